cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have parameter s_offset, default 5, meaning the log2 of line size in bytes; it aligns address_o.
REQ-002 The block SHALL have parameter s_line, default 256, meaning the cache line width in bits.
REQ-003 The block SHALL have parameter s_burst, default 64, meaning the memory beat width in bits; s_line/s_burst SHALL equal 4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset, where rst==0 at a rising edge resets the block.
REQ-006 The block SHALL have port line_i, input, s_line bits: the line to write, from the cache.
REQ-007 The block SHALL have port line_o, output, s_line bits: the assembled read line, to the cache.
REQ-008 The block SHALL have port address_i, input, 32 bits: the request byte address, from the cache.
REQ-009 The block SHALL have port read_i, input, 1 bit: the line read request, held by the cache until resp_o.
REQ-010 The block SHALL have port write_i, input, 1 bit: the line write request, held by the cache until resp_o.
REQ-011 The block SHALL have port resp_o, output, 1 bit: a one-cycle line completion pulse.
REQ-012 The block SHALL have port burst_i, input, s_burst bits: the read beat data, from memory.
REQ-013 The block SHALL have port burst_o, output, s_burst bits: the write beat data, to memory.
REQ-014 The block SHALL have port address_o, output, 32 bits: the line-aligned address, to memory.
REQ-015 The block SHALL have port read_o, output, 1 bit: the burst read request, to memory.
REQ-016 The block SHALL have port write_o, output, 1 bit: the burst write request, to memory.
REQ-017 The block SHALL have port resp_i, input, 1 bit: the beat valid/accept signal, from memory.

Function
REQ-018 The block SHALL implement states IDLE, READ, WRITE, DONE, held in a registered state with combinational outputs.
REQ-019 In IDLE, the block SHALL do the following:
- With write_i==1, go to WRITE, latching line_i into an internal line buffer and latching address_i.
- Else with read_i==1, go to READ, latching address_i.
- Else remain in IDLE.
REQ-020 When write_i and read_i are both 1 in IDLE, write SHALL win; read_i SHALL be ignored for that transaction.
REQ-021 address_o SHALL equal {latched_address[31:s_offset], s_offset zeros}, held constant for the whole transaction; in IDLE and DONE it SHALL be 0.
REQ-022 In READ, read_o SHALL be 1; each cycle with resp_i==1, the block SHALL do the following:
- Store burst_i into line buffer bits [64k+63:64k], where k is the 2-bit beat counter.
- Increment k.
REQ-023 In WRITE, write_o SHALL be 1 and burst_o SHALL equal line buffer bits [64k+63:64k]; each cycle with resp_i==1, k SHALL increment.
REQ-024 Cycles with resp_i==0 in READ/WRITE SHALL be wait states: no counter, buffer or output change.
REQ-025 On the beat where k==3 and resp_i==1, the block SHALL go to DONE and k SHALL wrap to 0; read_o/write_o SHALL be 0 from the next cycle.
REQ-026 In DONE, resp_o SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-027 line_o SHALL be driven from the line buffer at all times, so it is valid in the resp_o cycle and held until the next transaction modifies the buffer.
REQ-028 read_o and write_o SHALL never be 1 simultaneously; burst_o SHALL be 0 outside WRITE.
REQ-029 resp_i in IDLE or DONE SHALL be ignored.
REQ-030 Changes on read_i/write_i/address_i/line_i after acceptance SHALL be ignored until IDLE is re-entered.
REQ-031 The minimum latency with zero-wait memory SHALL be as follows:
- The request is sampled at edge 0.
- read_o/write_o are 1 in cycles 1-4, with resp_i=1 in cycles 1-4.
- resp_o is 1 in cycle 5.
- IDLE is reached at cycle 6.
REQ-032 A new request SHALL be accepted no earlier than the first IDLE cycle after resp_o.

Reset
REQ-033 rst==0 at a clock edge SHALL force:
- state IDLE, k=0, line buffer=0, latched address=0.
- Consequently resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0 and line_o=0 from the following cycle.
REQ-034 Reset mid-READ or mid-WRITE SHALL abandon the transaction with no resp_o, discarding partial beats.
REQ-035 rst has priority over all other inputs in the same cycle.

Verification
REQ-036 Read, zero wait: read_i=1, address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> the following:
- address_o=0x0000_1220.
- resp_o is 1 in one cycle.
- line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
REQ-037 Write with stalls: write_i=1, line_i={D3,D2,D1,D0}, resp_i pattern 1,0,0,1,1,0,1 -> the following:
- burst_o steps D0,D1,D1,D1,D2,D3,D3.
- write_o=1 for 7 cycles.
- resp_o pulses one cycle after the 4th accepted beat.
REQ-038 Simultaneous read_i=1 and write_i=1 in IDLE -> write_o=1, read_o stays 0 for the whole transaction.
REQ-039 Back-to-back write then read, the cache controller pattern -> the following:
- The second request is accepted only in IDLE after resp_o.
- No beat overlap.
- k starts at 0.
REQ-040 rst=0 after 2 read beats -> the following:
- read_o=0 and line_o=0 next cycle.
- No resp_o.
- A subsequent full read completes correctly.
REQ-041 resp_i=1 toggling while in IDLE and DONE -> no state change and no buffer change.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Converts a cache line request into a four-beat memory burst, assembling read beats into
// a line buffer and slicing the buffered write line into beats.
module cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_burst  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_beat;
    logic [s_line-1:0] r_line;
    logic [31:0]       r_addr;
    logic [31:0]       w_alignedAddr;
    logic              w_beatTaken;
    logic              w_lastBeat;
    logic              w_unusedAddrBits;

    // The byte offset within the line never reaches memory, so it is dropped at latch time.
    assign w_alignedAddr    = {address_i[31:s_offset], {s_offset{1'b0}}};
    assign w_unusedAddrBits = ^address_i[s_offset-1:0];

    assign w_beatTaken = resp_i && ((r_state == READ) || (r_state == WRITE));
    assign w_lastBeat  = w_beatTaken && (r_beat == 2'd3);
    assign line_o      = r_line;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        read_o      = 1'b0;
        write_o     = 1'b0;
        resp_o      = 1'b0;
        burst_o     = '0;
        address_o   = '0;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_nextState = WRITE;
                end else if (read_i) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                read_o    = 1'b1;
                address_o = r_addr;
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            WRITE: begin
                write_o   = 1'b1;
                address_o = r_addr;
                burst_o   = r_line[int'(r_beat)*s_burst +: s_burst];
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                resp_o      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The beat counter wraps naturally from 3 to 0, so the next transaction starts at beat 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat <= 2'd0;
            r_line <= '0;
            r_addr <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (write_i) begin
                    r_line <= line_i;
                    r_addr <= w_alignedAddr;
                end else if (read_i) begin
                    r_addr <= w_alignedAddr;
                end
            end
            if (w_beatTaken) begin
                r_beat <= r_beat + 2'd1;
                if (r_state == READ) begin
                    r_line[int'(r_beat)*s_burst +: s_burst] <= burst_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a behavioural memory answers bursts with random
// wait states while a monitor checks every completed line against queued expectations.
module tb_cacheline_adaptor;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [255:0] line;
    } txn_t;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int nCompared   = 0;
    int nMismatched = 0;

    txn_t        expQ[$];
    int          memMode = 1;
    bit          patt[$];
    logic [63:0] rdBeats[4];
    logic [63:0] wrBeats[4];
    logic [63:0] burstTrace[$];
    logic [31:0] seenAddr;
    bit          sawRead;
    bit          sawWrite;
    bit          addrUnstable;
    int          activeCycles;

    cacheline_adaptor #(
        .s_offset(5),
        .s_line  (256),
        .s_burst (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] randLine();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: decides per cycle whether to accept/deliver a beat; noise on resp_i when idle.
    initial begin
        int  beatCnt;
        bit  go;
        beatCnt = 0;
        resp_i  = 1'b0;
        burst_i = '0;
        forever begin
            @(negedge clk);
            if (read_o || write_o) begin
                case (memMode)
                    1:       go = 1'b1;
                    2:       go = (patt.size() > 0) ? patt.pop_front() : 1'b1;
                    default: go = ($urandom_range(0, 3) != 0);
                endcase
                if (activeCycles == 0) begin
                    seenAddr = address_o;
                end else if (address_o !== seenAddr) begin
                    addrUnstable = 1'b1;
                end
                activeCycles++;
                if (read_o) sawRead = 1'b1;
                if (write_o) begin
                    sawWrite = 1'b1;
                    burstTrace.push_back(burst_o);
                end
                burst_i = {$urandom, $urandom};
                if (go && beatCnt < 4) begin
                    if (write_o) wrBeats[beatCnt] = burst_o;
                    if (read_o) burst_i = rdBeats[beatCnt];
                    beatCnt++;
                end
                resp_i = go;
            end else begin
                beatCnt = 0;
                resp_i  = 1'($urandom_range(0, 1));
                burst_i = {$urandom, $urandom};
            end
        end
    end

    // Monitor: invariants every cycle, and a scoreboard pop on each completion pulse.
    initial begin
        txn_t e;
        bit   prevResp;
        prevResp = 1'b0;
        forever begin
            @(negedge clk);
            checkOutput("readWriteExclusive", 256'(read_o & write_o), 256'(0));
            if (!write_o) checkOutput("burstZeroOutsideWrite", 256'(burst_o), 256'(0));
            if (resp_o) begin
                checkOutput("respOneCycle", 256'(prevResp), 256'(0));
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResp", 256'(resp_o), 256'(0));
                end else if (!prevResp) begin
                    e = expQ.pop_front();
                    checkOutput("lineO", line_o, e.line);
                    checkOutput("memAddr", 256'(seenAddr), 256'(e.addr));
                    checkOutput("addrStable", 256'(addrUnstable), 256'(0));
                    checkOutput("sawRead", 256'(sawRead), 256'(!e.isWrite));
                    checkOutput("sawWrite", 256'(sawWrite), 256'(e.isWrite));
                    if (e.isWrite) begin
                        checkOutput("memWriteData", {wrBeats[3], wrBeats[2], wrBeats[1], wrBeats[0]}, e.line);
                    end
                end
            end
            prevResp = resp_o;
        end
    end

    // Issues one request in an IDLE cycle, scrambles the non-held inputs while it runs,
    // and returns the number of cycles until the completion pulse.
    task automatic applyStimulus(input bit wr, input bit both, input logic [31:0] addr,
                                 input logic [255:0] data, output int lat);
        txn_t e;
        @(negedge clk);
        sawRead      = 1'b0;
        sawWrite     = 1'b0;
        addrUnstable = 1'b0;
        activeCycles = 0;
        burstTrace.delete();
        for (int i = 0; i < 4; i++) begin
            rdBeats[i] = data[i*64 +: 64];
            wrBeats[i] = '0;
        end
        address_i = addr;
        line_i    = wr ? data : randLine();
        write_i   = wr;
        read_i    = !wr || both;
        e.isWrite = wr;
        e.addr    = addr & 32'hFFFF_FFE0;
        e.line    = data;
        expQ.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            address_i = $urandom;
            line_i    = randLine();
        end while (!resp_o && lat < 300);
        if (!resp_o) checkOutput("respTimeout", 256'(resp_o), 256'(1));
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        logic [255:0] d;
        int           expIdx[7];
        rst       = 1'b0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = 32'hDEAD_BEEF;
        line_i    = randLine();
        repeat (3) @(negedge clk);
        checkOutput("rstRespO", 256'(resp_o), 256'(0));
        checkOutput("rstReadO", 256'(read_o), 256'(0));
        checkOutput("rstWriteO", 256'(write_o), 256'(0));
        checkOutput("rstAddressO", 256'(address_o), 256'(0));
        checkOutput("rstBurstO", 256'(burst_o), 256'(0));
        checkOutput("rstLineO", line_o, 256'(0));
        rst = 1'b1;

        $display("[TB] zero-wait read of a fixed line");
        memMode = 1;
        d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        applyStimulus(1'b0, 1'b0, 32'h0000_1234, d, lat);
        checkOutput("readLatency", 256'(lat), 256'(5));
        checkOutput("readAddr1220", 256'(seenAddr), 256'(32'h0000_1220));

        // resp_i noise while idle must leave everything untouched
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idleLineHeld", line_o, d);
            checkOutput("idleNoRequest", 256'(read_o | write_o), 256'(0));
        end

        $display("[TB] write with stalled beats");
        memMode = 2;
        patt    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        expIdx  = '{0, 1, 1, 1, 2, 3, 3};
        d = randLine();
        applyStimulus(1'b1, 1'b0, $urandom, d, lat);
        checkOutput("stallWriteCycles", 256'(activeCycles), 256'(7));
        checkOutput("stallTraceLen", 256'(burstTrace.size()), 256'(7));
        for (int i = 0; i < 7 && i < burstTrace.size(); i++) begin
            checkOutput("stallBurstO", 256'(burstTrace[i]), 256'(d[expIdx[i]*64 +: 64]));
        end
        checkOutput("stallLatency", 256'(lat), 256'(8));

        $display("[TB] simultaneous read and write requests");
        memMode = 1;
        applyStimulus(1'b1, 1'b1, $urandom, randLine(), lat);
        checkOutput("bothLatency", 256'(lat), 256'(5));

        $display("[TB] back-to-back write then read");
        applyStimulus(1'b1, 1'b0, $urandom, randLine(), lat);
        checkOutput("b2bWriteLatency", 256'(lat), 256'(5));
        applyStimulus(1'b0, 1'b0, $urandom, randLine(), lat);
        checkOutput("b2bReadLatency", 256'(lat), 256'(5));

        $display("[TB] reset after two read beats");
        @(negedge clk);
        sawRead = 1'b0;
        sawWrite = 1'b0;
        activeCycles = 0;
        for (int i = 0; i < 4; i++) rdBeats[i] = {$urandom, $urandom};
        address_i = 32'h0000_8044;
        read_i    = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        read_i = 1'b0;
        @(negedge clk);
        checkOutput("midRstReadO", 256'(read_o), 256'(0));
        checkOutput("midRstLineO", line_o, 256'(0));
        checkOutput("midRstRespO", 256'(resp_o), 256'(0));
        checkOutput("midRstAddressO", 256'(address_o), 256'(0));
        rst = 1'b1;
        repeat (6) @(negedge clk);
        applyStimulus(1'b0, 1'b0, $urandom, randLine(), lat);
        checkOutput("postRstLatency", 256'(lat), 256'(5));

        $display("[TB] randomized traffic with random wait states");
        memMode = 0;
        for (int n = 0; n < 24; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(kind != 0, kind == 2, $urandom, randLine(), lat);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboardDrained", 256'(expQ.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
